// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: register-file geometry and alu control codes,
// so the control unit, alu and register file agree on one encoding.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd2;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_XOR = 4'b0011,
    ALU_SRL = 4'b0100
  } alu_ctrl_e;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            zero;
  } alu_out_t;

  // Reference alu behaviour; the zero flag is derived from the result.
  function automatic alu_out_t alu_compute(input logic [XLEN-1:0] a,
                                           input logic [XLEN-1:0] b,
                                           input alu_ctrl_e       ctrl);
    alu_out_t o;
    o.result = '0;
    case (ctrl)
      ALU_ADD: o.result = a + b;
      ALU_SUB: o.result = a - b;
      ALU_XOR: o.result = a ^ b;
      ALU_SRL: o.result = a >> b[4:0];
      default: o.result = '0;
    endcase
    o.zero = (o.result == '0);
    return o;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational register-file read port with optional write-first bypass.
// Index 0 and indices beyond NREGS read as zero.
module regfile_read_port
  import riscv_pkg::*;
#(
  parameter int XLEN_P = XLEN,
  parameter int NREGS  = 32
) (
  input  logic [REG_ADDR_W-1:0]        idx_i,
  input  logic [NREGS-1:0][XLEN_P-1:0] regs_i,
  input  logic                         byp_en_i,
  input  logic [REG_ADDR_W-1:0]        byp_idx_i,
  input  logic [XLEN_P-1:0]            byp_data_i,
  output logic [XLEN_P-1:0]            data_o
);

  logic [XLEN_P-1:0] stored;

  // Decoded mux: an index with no matching register leaves stored at zero.
  always_comb begin
    stored = '0;
    for (int r = 0; r < NREGS; r++)
      if (idx_i == REG_ADDR_W'(r)) stored = regs_i[r];
  end

  always_comb begin
    data_o = stored;
    if (idx_i == REG_ZERO)
      data_o = '0;
    else if (byp_en_i && (byp_idx_i == idx_i))
      data_o = byp_data_i;
  end

endmodule

// File: rtl/register_file.sv
// 32 x XLEN RV32I integer register file: two combinational read ports,
// one synchronous write port, x0 hardwired to zero, unbypassed debug port.
module register_file
  import riscv_pkg::*;
#(
  parameter int              XLEN_P   = XLEN,
  parameter int              NREGS    = 32,
  parameter int              BYPASS   = 1,
  parameter logic [XLEN_P-1:0] SP_RESET = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] readReg1,
  input  logic [REG_ADDR_W-1:0] readReg2,
  output logic [XLEN_P-1:0]     readData1,
  output logic [XLEN_P-1:0]     readData2,
  input  logic                  regWrite,
  input  logic [REG_ADDR_W-1:0] writeReg,
  input  logic [XLEN_P-1:0]     writeData,
  input  logic [REG_ADDR_W-1:0] dbgReg,
  output logic [XLEN_P-1:0]     dbgData
);

  logic [XLEN_P-1:0]             regs_q [NREGS-1:1];
  logic [NREGS-1:0][XLEN_P-1:0]  rf_view;
  logic                          wr_en;
  logic                          byp_en;

  assign wr_en  = regWrite && (writeReg != REG_ZERO);
  assign byp_en = (BYPASS != 0) && wr_en && !reset;

  // Out-of-range writeReg matches no register, so the write is dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < NREGS; i++)
        regs_q[i] <= (REG_ADDR_W'(i) == REG_SP) ? SP_RESET : '0;
    end else if (wr_en) begin
      for (int i = 1; i < NREGS; i++)
        if (writeReg == REG_ADDR_W'(i)) regs_q[i] <= writeData;
    end
  end

  // x0 has no flop; the read ports see a constant zero in its slot.
  for (genvar g = 0; g < NREGS; g++) begin : g_view
    if (g == 0) begin : g_zero
      assign rf_view[g] = '0;
    end else begin : g_reg
      assign rf_view[g] = regs_q[g];
    end
  end

  regfile_read_port #(.XLEN_P(XLEN_P), .NREGS(NREGS)) u_rp1 (
    .idx_i(readReg1), .regs_i(rf_view), .byp_en_i(byp_en),
    .byp_idx_i(writeReg), .byp_data_i(writeData), .data_o(readData1)
  );

  regfile_read_port #(.XLEN_P(XLEN_P), .NREGS(NREGS)) u_rp2 (
    .idx_i(readReg2), .regs_i(rf_view), .byp_en_i(byp_en),
    .byp_idx_i(writeReg), .byp_data_i(writeData), .data_o(readData2)
  );

  regfile_read_port #(.XLEN_P(XLEN_P), .NREGS(NREGS)) u_dbg (
    .idx_i(dbgReg), .regs_i(rf_view), .byp_en_i(1'b0),
    .byp_idx_i(writeReg), .byp_data_i(writeData), .data_o(dbgData)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: a bypassing and a non-bypassing instance
// share every input so write-first behaviour can be compared side by side.
module tb_register_file;
  import riscv_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  readReg1 = '0, readReg2 = '0, writeReg = '0, dbgReg = '0;
  logic        regWrite = 1'b0;
  logic [31:0] writeData = '0;
  logic [31:0] rd1, rd2, dbg, nb_rd1, nb_rd2, nb_dbg;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  register_file #(.BYPASS(1)) u_dut (
    .clock(clock), .reset(reset), .readReg1(readReg1), .readReg2(readReg2),
    .readData1(rd1), .readData2(rd2), .regWrite(regWrite), .writeReg(writeReg),
    .writeData(writeData), .dbgReg(dbgReg), .dbgData(dbg)
  );

  register_file #(.BYPASS(0)) u_nb (
    .clock(clock), .reset(reset), .readReg1(readReg1), .readReg2(readReg2),
    .readData1(nb_rd1), .readData2(nb_rd2), .regWrite(regWrite), .writeReg(writeReg),
    .writeData(writeData), .dbgReg(dbgReg), .dbgData(nb_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change #1 after the edge; checks follow after a settle delay.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d);
    regWrite = 1'b1; writeReg = r; writeData = d;
    tick();
    regWrite = 1'b0;
  endtask

  alu_out_t ao;

  initial begin
    // Reset state
    #2 reset = 1'b1;
    #1;
    readReg1 = 5'd2; dbgReg = 5'd5; #1;
    chk("rst_sp", rd1, 32'h0);
    chk("rst_dbg5", dbg, 32'h0);
    tick();
    reset = 1'b0;
    tick();

    // 1: mid-run reset clears state and blocks writes
    wr(5'd5, 32'h1234);
    dbgReg = 5'd5; #1;
    chk("pre_rst_x5", dbg, 32'h1234);
    regWrite = 1'b1; writeReg = 5'd7; writeData = 32'hAAAA_AAAA;
    readReg1 = 5'd7; readReg2 = 5'd5;
    #2 reset = 1'b1; #1;
    chk("rst_x5_dbg", dbg, 32'h0);
    chk("rst_x5_rd2", rd2, 32'h0);
    chk("rst_nobyp_x7", rd1, 32'h0);
    tick();
    dbgReg = 5'd7; #1;
    chk("rst_x7_dbg", dbg, 32'h0);
    regWrite = 1'b0; reset = 1'b0;
    tick();
    chk("post_rst_x7", rd1, 32'h0);

    // 2: basic write / read
    wr(5'd5, 32'hDEAD_BEEF);
    readReg1 = 5'd5; readReg2 = 5'd6; #1;
    chk("rd_x5", rd1, 32'hDEAD_BEEF);
    chk("rd_x6", rd2, 32'h0);

    // regWrite=0 leaves state untouched
    writeReg = 5'd5; writeData = 32'h0BAD_0BAD;
    tick();
    chk("nowe_x5", rd1, 32'hDEAD_BEEF);

    // 3: x0 stays zero
    regWrite = 1'b1; writeReg = 5'd0; writeData = 32'hFFFF_FFFF;
    readReg1 = 5'd0; dbgReg = 5'd0; #1;
    chk("x0_same", rd1, 32'h0);
    chk("x0_dbg", dbg, 32'h0);
    tick();
    regWrite = 1'b0; #1;
    chk("x0_next", rd1, 32'h0);
    chk("x0_next_dbg", dbg, 32'h0);

    // 4: bypass vs no bypass
    wr(5'd3, 32'h1);
    regWrite = 1'b1; writeReg = 5'd3; writeData = 32'h5;
    readReg1 = 5'd3; readReg2 = 5'd3; dbgReg = 5'd3; #1;
    chk("byp_rd1", rd1, 32'h5);
    chk("byp_rd2", rd2, 32'h5);
    chk("byp_dbg_pre", dbg, 32'h1);
    chk("nb_rd1_pre", nb_rd1, 32'h1);
    chk("nb_rd2_pre", nb_rd2, 32'h1);
    tick();
    regWrite = 1'b0; #1;
    chk("byp_dbg_post", dbg, 32'h5);
    chk("nb_rd1_post", nb_rd1, 32'h5);
    chk("nb_dbg_post", nb_dbg, 32'h5);

    // 5: register file feeding the alu
    wr(5'd1, 32'hFFFF_FFFF);
    wr(5'd2, 32'h2);
    readReg1 = 5'd1; readReg2 = 5'd2; #1;
    ao = alu_compute(rd1, rd2, ALU_ADD);
    chk("alu_add", ao.result, 32'h1);
    chk("alu_add_z", {31'b0, ao.zero}, 32'h0);
    wr(5'd1, 32'h5);
    #1;
    ao = alu_compute(rd1, rd2, ALU_SUB);
    chk("alu_sub", ao.result, 32'h3);
    chk("alu_sub_z", {31'b0, ao.zero}, 32'h0);

    // 6: sweep, no aliasing
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) * 32'h0101_0101);
    for (int i = 0; i < 32; i++) begin
      readReg1 = 5'(i); readReg2 = 5'(31 - i); dbgReg = 5'(i); #1;
      chk($sformatf("sw_rd1_%0d", i), rd1, 32'(i) * 32'h0101_0101);
      chk($sformatf("sw_rd2_%0d", 31 - i), rd2, 32'(31 - i) * 32'h0101_0101);
      chk($sformatf("sw_dbg_%0d", i), dbg, 32'(i) * 32'h0101_0101);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
